pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_ras.sv | 58 +++++
 rtl/pc_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select encodings.
package pc_pkg;

  // Next-PC mode selected on the Sel input
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_RET    = 2'b11
  } sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest entry.
// The overflow and underflow outputs are single-cycle pulses qualified by push/pop.
module pc_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] pushdata,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             dopop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(RAS_DEPTH));
  assign top       = mem[ptr - PTR_W'(1)];
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign dopop     = pop & ~empty & ~push;

  // Pointer names the next free slot; once the stack is full it names the oldest entry,
  // so a push always wraps onto the oldest entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (dopop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage is not reset; an entry cannot be read until it has been pushed.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[ptr] <= pushdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with sequential, branch, jump and return modes, plus a call/return stack.
// The only registers are PCout, the sticky error flags and the state held in pc_ras.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 8,
  parameter int RESET_VEC = 0,
  parameter int INC       = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            PCWrite,
  input  logic [1:0]      Sel,
  input  logic            Call,
  input  logic [PC_W-1:0] Offset,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PCout,
  output logic            RASEmpty,
  output logic            RASFull,
  output logic            RASOverflow,
  output logic            RASUnderflow
);

  logic [PC_W-1:0] seqpc;
  logic [PC_W-1:0] brpc;
  logic [PC_W-1:0] nextpc;
  logic [PC_W-1:0] rastop;
  logic            pushreq;
  logic            popreq;
  logic            raspush;
  logic            raspop;
  logic            ovfpulse;
  logic            unfpulse;

  assign seqpc = PCout + PC_W'(INC);
  assign brpc  = PCout + Offset;

  // Choose the next PC from Sel; Call only pushes on BRANCH or JUMP, and a RET on an
  // empty stack falls through to the sequential address.
  always_comb begin
    nextpc  = seqpc;
    pushreq = 1'b0;
    popreq  = 1'b0;
    case (Sel)
      SEL_BRANCH: begin
        nextpc  = brpc;
        pushreq = Call;
      end
      SEL_JUMP: begin
        nextpc  = Target;
        pushreq = Call;
      end
      SEL_RET: begin
        popreq = 1'b1;
        nextpc = RASEmpty ? seqpc : rastop;
      end
      default: begin
        nextpc = seqpc;
      end
    endcase
  end

  assign raspush = PCWrite & pushreq;
  assign raspop  = PCWrite & popreq;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (raspush),
    .pop       (raspop),
    .pushdata  (seqpc),
    .top       (rastop),
    .empty     (RASEmpty),
    .full      (RASFull),
    .overflow  (ovfpulse),
    .underflow (unfpulse)
  );

  // Advance the PC on enabled cycles; a stall holds it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCout <= PC_W'(RESET_VEC);
    end else if (PCWrite) begin
      PCout <= nextpc;
    end
  end

  // Stack error flags latch on the first occurrence and stay set until reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RASOverflow  <= 1'b0;
      RASUnderflow <= 1'b0;
    end else begin
      RASOverflow  <= RASOverflow | ovfpulse;
      RASUnderflow <= RASUnderflow | unfpulse;
    end
  end

endmodule
